// File: rtl/hack_pkg.sv
// Shared HACK CPU definitions: data/address widths, instruction type, fetch FSM states.
package hack_pkg;
    localparam int HACK_DW     = 16;
    localparam int HACK_ROM_AW = 15;

    typedef logic [HACK_DW-1:0] instr_t;

    typedef enum logic {F_IDLE, F_WAIT} fetch_state_t;
endpackage

// File: rtl/hack_fetch_unit_if.sv
// Fetch-stage bus: PC side, instruction ROM handshake and decode-side instruction stream.
interface hack_fetch_unit_if
    import hack_pkg::*;
#(
    parameter int AW = HACK_ROM_AW,
    parameter int DW = HACK_DW
);
    logic [15:0]   pc_addr;
    logic          jump;
    logic          pc_inc;
    logic          rom_req;
    logic [AW-1:0] rom_addr;
    logic          rom_valid;
    logic [DW-1:0] rom_data;
    logic [DW-1:0] instr;
    logic          instr_valid;
    logic          instr_ready;

    modport master (
        input  pc_addr, jump, rom_valid, rom_data, instr_ready,
        output pc_inc, rom_req, rom_addr, instr, instr_valid
    );
    modport slave (
        output pc_addr, jump, rom_valid, rom_data, instr_ready,
        input  pc_inc, rom_req, rom_addr, instr, instr_valid
    );
endinterface

// File: rtl/hack_instr_fifo.sv
// Small instruction buffer: DEPTH x DW registers, push/pop/flush, occupancy count.
module hack_instr_fifo
    import hack_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int DW    = HACK_DW,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output logic [DW-1:0] rdata_o,
    output logic [CW-1:0] count_o
);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [DEPTH-1:0][DW-1:0] mem_q;
    logic [PW-1:0]            wr_q, rd_q;
    logic [CW-1:0]            cnt_q;
    logic                     do_push, do_pop;

    assign do_pop  = pop_i & ~flush_i & (cnt_q != '0);
    assign do_push = push_i & ~flush_i & ((cnt_q != DEPTH_C) | do_pop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= wdata_i;
                wr_q        <= wr_q + 1'b1;
            end
            if (do_pop) rd_q <= rd_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign rdata_o = mem_q[rd_q];
    assign count_o = cnt_q;
endmodule

// File: rtl/hack_fetch_unit.sv
// HACK fetch stage: one outstanding ROM read, buffered words, PC advance only on capture.
module hack_fetch_unit
    import hack_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = HACK_ROM_AW,
    parameter int DW    = HACK_DW
) (
    input  logic              clk,
    input  logic              rst,
    hack_fetch_unit_if.master bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fetch_state_t  state_q, state_d;
    logic          drop_q, drop_d;
    logic          pc_inc, pc_inc_q;
    logic [AW-1:0] addr_q, addr_d;
    logic [CW-1:0] count;
    logic [DW-1:0] head;
    logic          unused_pc_bits;

    assign unused_pc_bits = &{1'b0, bus.pc_addr};

    // pc_inc_q holds off issue for a cycle so pc_addr has settled to PC+1.
    always_comb begin
        state_d = state_q;
        drop_d  = drop_q;
        addr_d  = addr_q;
        pc_inc  = 1'b0;
        case (state_q)
            F_IDLE: begin
                if (!bus.jump && !pc_inc_q && (count < DEPTH_C)) begin
                    state_d = F_WAIT;
                    addr_d  = bus.pc_addr[AW-1:0];
                end
            end
            F_WAIT: begin
                if (bus.rom_valid) begin
                    state_d = F_IDLE;
                    drop_d  = 1'b0;
                    pc_inc  = ~drop_q & ~bus.jump;
                end else if (bus.jump) begin
                    drop_d = 1'b1;
                end
            end
            default: state_d = F_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= F_IDLE;
            drop_q   <= 1'b0;
            addr_q   <= '0;
            pc_inc_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            drop_q   <= drop_d;
            addr_q   <= addr_d;
            pc_inc_q <= pc_inc;
        end
    end

    hack_instr_fifo #(.DEPTH(DEPTH), .DW(DW)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (pc_inc),
        .wdata_i (bus.rom_data),
        .pop_i   (bus.instr_valid & bus.instr_ready),
        .flush_i (bus.jump),
        .rdata_o (head),
        .count_o (count)
    );

    assign bus.pc_inc      = pc_inc;
    assign bus.rom_req     = (state_q == F_WAIT);
    assign bus.rom_addr    = addr_q;
    assign bus.instr       = head;
    assign bus.instr_valid = (count != '0);
endmodule
